alu_core: RTL and testbench
===========================

ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 The parameter DATA_W SHALL default to 32 and set the operand and result width; only 32 is required to be supported.
REQ-002 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and be the synchronous, active-low reset.
REQ-004 The port in_valid SHALL be an input, 1 bit wide, and qualify the operands and opcode for capture.
REQ-005 The port oprd1 SHALL be an input, DATA_W bits wide, and carry operand A.
REQ-006 The port oprd2 SHALL be an input, DATA_W bits wide, and carry operand B.
REQ-007 The port ALU_Operation SHALL be an input, 4 bits wide, and carry the opcode.
REQ-008 The port result SHALL be an output, DATA_W bits wide, and be registered.
REQ-009 The port zero SHALL be an output, 1 bit wide, and be registered; it is 1 when result is all-zero.
REQ-010 The port overflow SHALL be an output, 1 bit wide, and be registered; it flags signed overflow on ADD or SUB.
REQ-011 The port out_valid SHALL be an output, 1 bit wide, and be registered; it marks result, zero and overflow as valid.

Function
REQ-012 Opcode 0000 SHALL produce oprd1 AND oprd2 (bitwise).
REQ-013 Opcode 0001 SHALL produce oprd1 OR oprd2 (bitwise).
REQ-014 Opcode 0010 SHALL produce oprd1 + oprd2, modulo 2^32, with the carry discarded.
REQ-015 Opcode 0110 SHALL produce oprd1 - oprd2, modulo 2^32.
REQ-016 Opcode 0111 SHALL produce 1 if oprd1 < oprd2 as two's-complement signed values, else 0; equal operands give 0.
REQ-017 Opcode 1100 SHALL produce ~(oprd1 | oprd2).
REQ-018 Any other opcode SHALL produce result 0, zero 1 and overflow 0.
REQ-019 The zero output SHALL be computed from the registered result value of the same operation; this also holds for NOR and SLT.
REQ-020 The overflow output SHALL be set when the operands have the same sign and the sum's sign differs (ADD), or when the operands have different signs and the difference's sign differs from oprd1 (SUB); it SHALL be 0 for all other opcodes.
REQ-021 Latency SHALL be exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear at the outputs after edge N, with out_valid=1.
REQ-022 A cycle with in_valid=0 SHALL hold result, zero and overflow, and set out_valid to 0 at the next edge.
REQ-023 The block SHALL accept one operation per cycle with no backpressure; back-to-back operations SHALL be supported.

Reset
REQ-024 While rst_n=0 at a rising clk edge, the block SHALL set result=0, zero=1, overflow=0 and out_valid=0.
REQ-025 Reset SHALL take priority over in_valid; an operation presented in the reset cycle SHALL be discarded.
REQ-026 The first operation after rst_n returns to 1 SHALL follow the normal 1-cycle latency.

Configuration
REQ-027 When the macro ALU_EXT_OPS_EN is defined, the block SHALL add these opcodes:
  - 0011: XOR.
  - 0100: SLL by oprd2[4:0].
  - 0101: SRL by oprd2[4:0].
  - 1000: SRA by oprd2[4:0].
  - 1001: SLTU, unsigned less-than giving 1 or 0.
REQ-028 When ALU_EXT_OPS_EN is not defined, those opcodes SHALL fall under REQ-018, and no shifter logic SHALL be synthesized.

Structure
REQ-029 A shared package alu_pkg SHALL hold the opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR and the extended opcodes) and DATA_W.
REQ-030 The purely combinational datapath SHALL be a sub-module alu_comb (operands and opcode in; result and overflow out); alu_core SHALL contain the registers, zero generation and valid logic.

Verification
REQ-031 The bench SHALL cover bitwise and NOR cases:
  - AND: 12, 10 -> result 8, zero 0.
  - OR: 12, 10 -> 14.
  - NOR: 7, 11 -> 0xFFFFFFF0.
  - NOR: 12, 5 -> 0xFFFFFFF2.
REQ-032 The bench SHALL cover arithmetic cases:
  - ADD: 15 + 20 -> 35.
  - ADD: -10 + 5 -> 0xFFFFFFFB.
  - SUB: 100 - 30 -> 70.
  - SUB: 50 - 50 -> 0 with zero=1.
  - SUB: -10 - (-10) -> 0 with zero=1.
REQ-033 The bench SHALL cover SLT cases:
  - 10 vs 20 -> 1.
  - 20 vs 10 -> 0.
  - 20 vs 20 -> 0.
  - -5 vs 10 -> 1.
REQ-034 The bench SHALL cover overflow:
  - ADD: 0x7FFFFFFF + 1 -> 0x80000000 with overflow=1.
  - SUB: 0x80000000 - 1 -> overflow=1.
  - ADD: 5 + 3 -> overflow=0.
REQ-035 The bench SHALL cover timing and reset:
  - Back-to-back ADD then SUB: results appear on consecutive cycles, each 1 cycle after its inputs.
  - Asserting rst_n=0 while in_valid=1: next edge gives result 0, zero 1, out_valid 0.
REQ-036 The bench SHALL cover illegal opcodes:
  - Opcode 1111 -> result 0, zero 1.
  - Opcode 0011 with 0xF0, 0xFF -> 0x0F only if ALU_EXT_OPS_EN is defined, else 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings and datapath width for alu_core and
//               alu_comb. The extended encodings are used only when
//               ALU_EXT_OPS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb
// Description : Purely combinational ALU datapath: result and signed overflow
//               from two operands and an opcode. Defining ALU_EXT_OPS_EN adds
//               XOR, SLL, SRL, SRA and SLTU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] i_oprd1,
    input  logic [DATA_W-1:0] i_oprd2,
    input  logic [3:0]        i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_overflow
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_slt;
    logic              w_add_ovf;
    logic              w_sub_ovf;

    assign w_sum  = i_oprd1 + i_oprd2;
    assign w_diff = i_oprd1 - i_oprd2;
    assign w_slt  = ($signed(i_oprd1) < $signed(i_oprd2));

    // Overflow is derived from operand/result sign bits only.
    assign w_add_ovf = (i_oprd1[MSB] == i_oprd2[MSB]) && (w_sum[MSB]  != i_oprd1[MSB]);
    assign w_sub_ovf = (i_oprd1[MSB] != i_oprd2[MSB]) && (w_diff[MSB] != i_oprd1[MSB]);

`ifdef ALU_EXT_OPS_EN
    localparam int SHAMT_W = $clog2(DATA_W);

    logic [SHAMT_W-1:0] w_shamt;
    logic [DATA_W-1:0]  w_sll;
    logic [DATA_W-1:0]  w_srl;
    logic [DATA_W-1:0]  w_sra;
    logic               w_sltu;

    assign w_shamt = i_oprd2[SHAMT_W-1:0];
    assign w_sll   = i_oprd1 << w_shamt;
    assign w_srl   = i_oprd1 >> w_shamt;
    assign w_sra   = $unsigned($signed(i_oprd1) >>> w_shamt);
    assign w_sltu  = (i_oprd1 < i_oprd2);
`endif

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_op)
            OP_AND: o_result = i_oprd1 & i_oprd2;
            OP_OR:  o_result = i_oprd1 | i_oprd2;
            OP_ADD: begin
                o_result   = w_sum;
                o_overflow = w_add_ovf;
            end
            OP_SUB: begin
                o_result   = w_diff;
                o_overflow = w_sub_ovf;
            end
            OP_SLT: o_result = {{(DATA_W-1){1'b0}}, w_slt};
            OP_NOR: o_result = ~(i_oprd1 | i_oprd2);
`ifdef ALU_EXT_OPS_EN
            OP_XOR:  o_result = i_oprd1 ^ i_oprd2;
            OP_SLL:  o_result = w_sll;
            OP_SRL:  o_result = w_srl;
            OP_SRA:  o_result = w_sra;
            OP_SLTU: o_result = {{(DATA_W-1){1'b0}}, w_sltu};
`endif
            default: begin
                o_result   = '0;
                o_overflow = 1'b0;
            end
        endcase
    end

endmodule : alu_comb
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Single-cycle registered ALU: captures operands when in_valid
//               is high and presents result/zero/overflow one cycle later.
//               Extended opcodes are enabled by defining ALU_EXT_OPS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] oprd1,
    input  logic [DATA_W-1:0] oprd2,
    input  logic [3:0]        ALU_Operation,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic              out_valid
);

    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_overflow;

    logic [DATA_W-1:0] w_result_d;
    logic              w_zero_d;
    logic              w_overflow_d;
    logic              w_out_valid_d;

    logic [DATA_W-1:0] r_result_q;
    logic              r_zero_q;
    logic              r_overflow_q;
    logic              r_out_valid_q;

    alu_comb #(
        .DATA_W (DATA_W)
    ) u_alu_comb (
        .i_oprd1    (oprd1),
        .i_oprd2    (oprd2),
        .i_op       (ALU_Operation),
        .o_result   (w_alu_result),
        .o_overflow (w_alu_overflow)
    );

    // Idle cycles keep the last result visible and only drop out_valid.
    always_comb begin
        w_result_d    = r_result_q;
        w_zero_d      = r_zero_q;
        w_overflow_d  = r_overflow_q;
        w_out_valid_d = 1'b0;
        if (in_valid) begin
            w_result_d    = w_alu_result;
            w_zero_d      = (w_alu_result == '0);
            w_overflow_d  = w_alu_overflow;
            w_out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result_q    <= '0;
            r_zero_q      <= 1'b1;
            r_overflow_q  <= 1'b0;
            r_out_valid_q <= 1'b0;
        end else begin
            r_result_q    <= w_result_d;
            r_zero_q      <= w_zero_d;
            r_overflow_q  <= w_overflow_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign result    = r_result_q;
    assign zero      = r_zero_q;
    assign overflow  = r_overflow_q;
    assign out_valid = r_out_valid_q;

endmodule : alu_core
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_core
// Description : Scoreboard bench for alu_core; an arithmetic reference model
//               predicts every cycle's outputs. Honours ALU_EXT_OPS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] oprd1;
    logic [31:0] oprd2;
    logic [3:0]  ALU_Operation;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        out_valid;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        v;
        string       name;
    } exp_t;

    exp_t        scb[$];
    int          n_cmp;
    int          n_err;
    logic [31:0] m_res;
    logic        m_z;
    logic        m_ov;

    alu_core #(
        .DATA_W (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .oprd1         (oprd1),
        .oprd2         (oprd2),
        .ALU_Operation (ALU_Operation),
        .result        (result),
        .zero          (zero),
        .overflow      (overflow),
        .out_valid     (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: operands as mathematical integers, overflow = out of signed range.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ov);
        longint sa;
        longint sbv;
        longint s;
        longint lim_hi;
        longint lim_lo;
        logic [4:0] sh;
        sa     = longint'($signed(a));
        sbv    = longint'($signed(b));
        lim_hi = 64'sd2147483647;
        lim_lo = -64'sd2147483648;
        sh     = b[4:0];
        r      = 32'd0;
        ov     = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                s  = sa + sbv;
                r  = s[31:0];
                ov = (s > lim_hi) || (s < lim_lo);
            end
            4'b0110: begin
                s  = sa - sbv;
                r  = s[31:0];
                ov = (s > lim_hi) || (s < lim_lo);
            end
            4'b0111: r = (sa < sbv) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
`ifdef ALU_EXT_OPS_EN
            4'b0011: r = a ^ b;
            4'b0100: r = a << sh;
            4'b0101: r = a >> sh;
            4'b1000: begin
                s = sa >>> sh;
                r = s[31:0];
            end
            4'b1001: r = (a < b) ? 32'd1 : 32'd0;
`endif
            default: r = 32'd0;
        endcase
    endfunction

    // Drive one cycle of stimulus and queue the expected outputs after the next edge.
    task automatic issue(input logic rst, input logic vld, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input string nm);
        exp_t        e;
        logic [31:0] r;
        logic        ov;
        @(negedge clk);
        rst_n         = rst;
        in_valid      = vld;
        ALU_Operation = op;
        oprd1         = a;
        oprd2         = b;
        if (!rst) begin
            m_res = 32'd0;
            m_z   = 1'b1;
            m_ov  = 1'b0;
            e.v   = 1'b0;
        end else if (vld) begin
            model(op, a, b, r, ov);
            m_res = r;
            m_z   = (r == 32'd0);
            m_ov  = ov;
            e.v   = 1'b1;
        end else begin
            e.v   = 1'b0;
        end
        e.res  = m_res;
        e.z    = m_z;
        e.ov   = m_ov;
        e.name = nm;
        scb.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, checked 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (scb.size() > 0) begin
                e = scb.pop_front();
                n_cmp++;
                if (result !== e.res || zero !== e.z || overflow !== e.ov || out_valid !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got result=%h zero=%b ovf=%b valid=%b, want result=%h zero=%b ovf=%b valid=%b",
                             e.name, result, zero, overflow, out_valid, e.res, e.z, e.ov, e.v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        logic [3:0] ops[16];
        n_cmp         = 0;
        n_err         = 0;
        m_res         = 32'd0;
        m_z           = 1'b1;
        m_ov          = 1'b0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        oprd1         = 32'd0;
        oprd2         = 32'd0;
        ALU_Operation = 4'd0;
        for (int i = 0; i < 16; i++) ops[i] = 4'(i);

        issue(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0, "reset_idle");
        issue(1'b0, 1'b1, 4'b0010, 32'd5, 32'd6, "reset_with_valid");

        issue(1'b1, 1'b1, 4'b0000, 32'd12, 32'd10, "and_12_10");
        issue(1'b1, 1'b1, 4'b0001, 32'd12, 32'd10, "or_12_10");
        issue(1'b1, 1'b1, 4'b1100, 32'd7, 32'd11, "nor_7_11");
        issue(1'b1, 1'b1, 4'b1100, 32'd12, 32'd5, "nor_12_5");
        issue(1'b1, 1'b1, 4'b0010, 32'd15, 32'd20, "add_15_20");
        issue(1'b1, 1'b1, 4'b0010, -32'sd10, 32'd5, "add_m10_5");
        issue(1'b1, 1'b1, 4'b0110, 32'd100, 32'd30, "sub_100_30");
        issue(1'b1, 1'b1, 4'b0110, 32'd50, 32'd50, "sub_50_50");
        issue(1'b1, 1'b1, 4'b0110, -32'sd10, -32'sd10, "sub_m10_m10");
        issue(1'b1, 1'b1, 4'b0111, 32'd10, 32'd20, "slt_10_20");
        issue(1'b1, 1'b1, 4'b0111, 32'd20, 32'd10, "slt_20_10");
        issue(1'b1, 1'b1, 4'b0111, 32'd20, 32'd20, "slt_20_20");
        issue(1'b1, 1'b1, 4'b0111, -32'sd5, 32'd10, "slt_m5_10");
        issue(1'b1, 1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1, "add_ovf");
        issue(1'b1, 1'b1, 4'b0110, 32'h8000_0000, 32'd1, "sub_ovf");
        issue(1'b1, 1'b1, 4'b0010, 32'd5, 32'd3, "add_no_ovf");
        issue(1'b1, 1'b0, 4'b0010, 32'd9, 32'd9, "idle_hold");
        issue(1'b1, 1'b1, 4'b0010, 32'd1, 32'd2, "b2b_add");
        issue(1'b1, 1'b1, 4'b0110, 32'd9, 32'd4, "b2b_sub");
        issue(1'b1, 1'b1, 4'b1111, 32'd33, 32'd44, "illegal_1111");
        issue(1'b1, 1'b1, 4'b0011, 32'h0000_00F0, 32'h0000_00FF, "op_0011");
        issue(1'b1, 1'b1, 4'b0010, 32'd3, 32'd4, "pre_reset_op");
        issue(1'b0, 1'b1, 4'b0010, 32'd3, 32'd4, "reset_mid_stream");
        issue(1'b1, 1'b1, 4'b0001, 32'd1, 32'd2, "first_after_reset");

        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 15)];
            case ($urandom_range(0, 3))
                0:       issue(1'b1, ($urandom_range(0, 5) != 0), op, $urandom, $urandom, "rand");
                1:       issue(1'b1, 1'b1, op, {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'($urandom)},
                               32'($urandom_range(0, 40)), "rand_small_b");
                2:       issue(1'b1, 1'b1, op, 32'h7FFF_FFFF - 32'($urandom_range(0, 3)),
                               32'h8000_0000 + 32'($urandom_range(0, 3)), "rand_edge");
                default: issue(($urandom_range(0, 30) != 0), $urandom_range(0, 1) == 1, op,
                               $urandom, $urandom, "rand_rst");
            endcase
        end

        for (int i = 0; i < 10 && scb.size() != 0; i++) @(posedge clk);
        #2;
        if (scb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", scb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_core
`default_nettype wire
